// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared constants for the write-back trace buffer.
// An entry is {kind, pc, addr, data} = 1 + 32 + 32 + 32 = 97 bits.
package wb_trace_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    localparam int unsigned ENTRY_W  = 97;
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned ADDR_LSB = 32;
    localparam int unsigned PC_LSB   = 64;
    localparam int unsigned KIND_BIT = 96;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic        kind,
        input logic [31:0] pc,
        input logic [31:0] addr,
        input logic [31:0] data
    );
        return {kind, pc, addr, data};
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: circular FIFO with up to two pushes and one pop per edge.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   wr_n_i         number of entries written this edge (0..2); caller never exceeds free_o
//   wr_data0_i/1_i entries written, data0 first
//   pop_i          pop request (ignored while empty)
//   head_o         oldest entry
//   valid_o        FIFO non-empty
//   free_o         slots available on this edge, counting a same-edge pop
module wb_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 97,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       wr_n_i,
    input  logic [WIDTH-1:0] wr_data0_i,
    input  logic [WIDTH-1:0] wr_data1_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [AW:0]      free_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, wptr_nxt;
    logic [AW:0]      count_q, count_d;
    logic             pop_eff;

    always_comb begin
        pop_eff  = pop_i && (count_q != '0);
        free_o   = (AW+1)'(DEPTH) - count_q + {{AW{1'b0}}, pop_eff};
        wptr_nxt = wptr_q + AW'(1);
        wptr_d   = wptr_q + AW'(wr_n_i);
        rptr_d   = rptr_q + {{(AW-1){1'b0}}, pop_eff};
        count_d  = count_q + (AW+1)'(wr_n_i) - {{AW{1'b0}}, pop_eff};
        valid_o  = (count_q != '0);
        head_o   = mem_q[rptr_q];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset: entries are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (wr_n_i != 2'd0) mem_q[wptr_q]   <= wr_data0_i;
        if (wr_n_i == 2'd2) mem_q[wptr_nxt] <= wr_data1_i;
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: queues GRF write and DM store events from the mips core and
// presents them one at a time on a valid/ready port.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   grf_we/pc/addr/wdata            register-file write tap
//   dm_we/pc/addr/wdata             data-memory store tap
//   out_valid/out_ready             head handshake
//   out_kind/pc/addr/data           head entry fields, zero while !out_valid
//   overflow                        sticky, set once any event is dropped
//   drop_cnt                        saturating dropped-event count
// Build option: define WB_TRACE_ZERO_FILTER_EN to discard GRF writes to $0 at input.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grf_we,
    input  logic [31:0]      grf_pc,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_wdata,
    input  logic             dm_we,
    input  logic [31:0]      dm_pc,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_kind,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic               grf_ev, dm_ev, pop, fifo_valid;
    logic [1:0]         n_req, n_acc, n_drop;
    logic [AW:0]        free;
    logic [ENTRY_W-1:0] grf_entry, dm_entry, wr_data0, head;
    logic [CNT_W:0]     drop_sum;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

`ifdef WB_TRACE_ZERO_FILTER_EN
    assign grf_ev = grf_we && (grf_addr != 5'd0);
`else
    assign grf_ev = grf_we;
`endif
    assign dm_ev = dm_we;

    always_comb begin
        grf_entry = pack_entry(KIND_GRF, grf_pc, {27'd0, grf_addr}, grf_wdata);
        dm_entry  = pack_entry(KIND_DM, dm_pc, dm_addr, dm_wdata);
        n_req     = {1'b0, grf_ev} + {1'b0, dm_ev};
        if (free >= (AW+1)'(2))      n_acc = n_req;
        else if (free == (AW+1)'(1)) n_acc = (n_req != 2'd0) ? 2'd1 : 2'd0;
        else                         n_acc = 2'd0;
        n_drop = n_req - n_acc;
        // With one slot the first write is the GRF event when present, so DM is the one lost.
        wr_data0 = grf_ev ? grf_entry : dm_entry;
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        overflow_d = overflow_q || (n_drop != 2'd0);
        pop        = fifo_valid && out_ready;
    end

    wb_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_n_i     (n_acc),
        .wr_data0_i (wr_data0),
        .wr_data1_i (dm_entry),
        .pop_i      (pop),
        .head_o     (head),
        .valid_o    (fifo_valid),
        .free_o     (free)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        out_valid = fifo_valid;
        out_kind  = fifo_valid ? head[KIND_BIT] : 1'b0;
        out_pc    = fifo_valid ? head[PC_LSB +: 32] : 32'd0;
        out_addr  = fifo_valid ? head[ADDR_LSB +: 32] : 32'd0;
        out_data  = fifo_valid ? head[DATA_LSB +: 32] : 32'd0;
        overflow  = overflow_q;
        drop_cnt  = drop_cnt_q;
    end

endmodule
